// File: rtl/rsa_pkg.sv
// Shared RSA datapath definitions: default operand width, counter width and
// the modular-multiplier state encoding.
package rsa_pkg;

  localparam int RSA_WIDTH      = 32;
  localparam int RSA_CNTR_WIDTH = 6;

  typedef enum logic [1:0] {
    MM_IDLE,
    MM_RUN,
    MM_DONE
  } mm_state_t;

endpackage

// File: rtl/modmul_step.sv
// One MSB-first interleaved modular-multiply step: P' = (2P + bit*B) mod N,
// assuming P < N and B < N on entry. Purely combinational.
module modmul_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  input  logic             a_bit,
  output logic [WIDTH-1:0] p_next
);

  // Two guard bits: 2P + B can reach just under 3N.
  logic [WIDTH+1:0] n_x;
  logic [WIDTH+1:0] t0;
  logic [WIDTH+1:0] t1;
  logic [WIDTH+1:0] t2;

  assign n_x    = {2'b00, n};
  assign t0     = {1'b0, p, 1'b0} + (a_bit ? {2'b00, b} : '0);
  assign t1     = (t0 >= n_x) ? (t0 - n_x) : t0;
  assign t2     = (t1 >= n_x) ? (t1 - n_x) : t1;
  assign p_next = t2[WIDTH-1:0];

endmodule

// File: rtl/mod_mult_interleaved.sv
// Bit-serial interleaved modular multiplier, result = (a*b) mod n, one bit of a
// per clock, MSB first. Define MODMUL_RANGE_CHECK_EN to add the err output.
module mod_mult_interleaved
  import rsa_pkg::*;
#(
  parameter int WIDTH      = RSA_WIDTH,
  parameter int CNTR_WIDTH = RSA_CNTR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef MODMUL_RANGE_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam logic [CNTR_WIDTH-1:0] CNT_LAST = CNTR_WIDTH'(WIDTH - 1);

  mm_state_t             state;
  mm_state_t             state_next;
  logic [WIDTH-1:0]      a_r;
  logic [WIDTH-1:0]      b_r;
  logic [WIDTH-1:0]      n_r;
  logic [WIDTH-1:0]      p;
  logic [WIDTH-1:0]      p_next;
  logic [WIDTH-1:0]      p_final;
  logic [CNTR_WIDTH-1:0] cnt;
  logic                  accept;
  logic                  last;

  assign accept = (state == MM_IDLE) && start;
  assign last   = (state == MM_RUN) && (cnt == CNT_LAST);
  assign busy   = (state != MM_IDLE);
  assign done   = (state == MM_DONE);

  // a_r shifts left each step so its MSB is always the current multiplier bit.
  modmul_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p      (p),
    .b      (b_r),
    .n      (n_r),
    .a_bit  (a_r[WIDTH-1]),
    .p_next (p_next)
  );

`ifdef MODMUL_RANGE_CHECK_EN
  assign p_final = err ? '0 : p_next;
`else
  assign p_final = p_next;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MM_IDLE;
    else      state <= state_next;
  end

  // NOTE: next-state defaults to the current state before the case so no
  // path leaves state_next unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      MM_IDLE: if (start) state_next = MM_RUN;
      MM_RUN:  if (cnt == CNT_LAST) state_next = MM_DONE;
      MM_DONE: state_next = MM_IDLE;
      default: state_next = MM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r    <= '0;
      b_r    <= '0;
      n_r    <= '0;
      p      <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      a_r <= a;
      b_r <= b;
      n_r <= n;
      p   <= '0;
      cnt <= '0;
    end else if (state == MM_RUN) begin
      a_r <= {a_r[WIDTH-2:0], 1'b0};
      p   <= p_next;
      if (last) result <= p_final;
      else      cnt    <= cnt + 1'b1;
    end
  end

`ifdef MODMUL_RANGE_CHECK_EN
  // Flag is a snapshot of the operands as accepted; held until the next accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        err <= 1'b0;
    else if (accept) err <= (n == '0) || (a >= n) || (b >= n);
  end
`endif

endmodule

// File: tb/tb_mod_mult_interleaved.sv
// Directed self-checking bench for mod_mult_interleaved at WIDTH=8.
module tb_mod_mult_interleaved;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] n;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
`ifdef MODMUL_RANGE_CHECK_EN
  logic         err;
`endif

  int total = 0;
  int bad   = 0;

  mod_mult_interleaved #(
    .WIDTH      (W),
    .CNTR_WIDTH (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef MODMUL_RANGE_CHECK_EN
    ,
    .err    (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] n;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  vec_t vecs[10];
  vec_t b2b[3];
  logic [W-1:0] prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full operation: start pulsed for one cycle, operands scrambled after
  // accept, latency/pulse/hold checked along the way.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic [W-1:0] tn, input logic [W-1:0] exp,
                       input logic [W-1:0] held, input string name);
    int cycles;
    @(negedge clk);
    a = ta; b = tb_v; n = tn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ta; b = ~tb_v; n = tn ^ 8'h5a;
    check({name, " busy after accept"}, busy, 1);
    check({name, " result held"}, result, held);
    cycles = 0;
    while (!done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({name, " done latency"}, cycles, W);
    check({name, " result"}, result, exp);
    @(posedge clk); #1;
    check({name, " done pulse width"}, done, 0);
    check({name, " idle after done"}, busy, 0);
  endtask

  initial begin
    int e;
    int dones;
    vecs[0] = '{8'd7,   8'd9,   8'd13,  8'd11, "7*9%13"};
    vecs[1] = '{8'd254, 8'd254, 8'd255, 8'd1,  "254*254%255"};
    vecs[2] = '{8'd12,  8'd12,  8'd13,  8'd1,  "12*12%13"};
    vecs[3] = '{8'd0,   8'd5,   8'd13,  8'd0,  "0*5%13"};
    vecs[4] = '{8'd100, 8'd200, 8'd251, 8'd171,"100*200%251"};
    vecs[5] = '{8'd1,   8'd1,   8'd2,   8'd1,  "1*1%2"};
    vecs[6] = '{8'd0,   8'd0,   8'd1,   8'd0,  "n=1"};
    vecs[7] = '{8'd200, 8'd150, 8'd211, 8'd38, "200*150%211"};
    vecs[8] = '{8'd128, 8'd128, 8'd255, 8'd64, "128*128%255"};
    vecs[9] = '{8'd5,   8'd0,   8'd7,   8'd0,  "5*0%7"};
    b2b[0]  = '{8'd5,   8'd6,   8'd7,   8'd2,  "b2b 5*6%7"};
    b2b[1]  = '{8'd3,   8'd4,   8'd13,  8'd12, "b2b 3*4%13"};
    b2b[2]  = '{8'd254, 8'd254, 8'd255, 8'd1,  "b2b 254*254%255"};

    rst = 1'b0; start = 1'b0; a = '0; b = '0; n = '0;
    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
`ifdef MODMUL_RANGE_CHECK_EN
    check("reset err", err, 0);
`endif
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("idle without start", busy, 0);

    prev = '0;
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].exp, prev, vecs[i].name);
      prev = vecs[i].exp;
    end

    // start held high: accepts only in IDLE, every W+2 edges.
    @(negedge clk);
    start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      a = b2b[j].a; b = b2b[j].b; n = b2b[j].n;
      @(posedge clk);
      e = 0; dones = 0;
      forever begin
        @(negedge clk);
        if (done) begin
          dones++;
          check({b2b[j].name, " result"}, result, b2b[j].exp);
        end
        if (!busy || e >= 40) break;
        a = 8'(e * 37); b = 8'(e * 11); n = 8'(e * 3 + 1);
        @(posedge clk);
        e++;
      end
      check({b2b[j].name, " spacing"}, e + 1, W + 2);
      check({b2b[j].name, " done count"}, dones, 1);
    end
    start = 1'b0;
    prev = b2b[2].exp;

    // Asynchronous reset mid-run: outputs clear at once, no done follows.
    @(negedge clk);
    a = 8'd7; b = 8'd9; n = 8'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort result", result, 0);
    @(negedge clk); rst = 1'b1;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort no done", dones, 0);
    do_op(8'd7, 8'd9, 8'd13, 8'd11, 8'd0, "after abort");

`ifdef MODMUL_RANGE_CHECK_EN
    do_op(8'd13, 8'd2, 8'd13, 8'd0, 8'd11, "range a>=n");
    check("range err set", err, 1);
    do_op(8'd3, 8'd4, 8'd13, 8'd12, 8'd0, "range ok");
    check("range err clear", err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mod_mult_interleaved.md
Name: mod_mult_interleaved

Overview:
- Bit-serial interleaved modular multiplier: computes R = (A * B) mod N, one multiplier bit per clock, MSB first.
- Sits directly upstream of the RSA iteration counter (`counter`) and the exponentiation sequencer.
- The exponentiation sequencer issues one multiply per square/multiply step and consumes `result` on `done`.
- Contains its own bit-iteration counter; its end value is WIDTH-1.

Parameters:
- WIDTH, 32, operand/modulus width in bits (>=2).
- CNTR_WIDTH, 6, iteration counter width; must satisfy 2**CNTR_WIDTH >= WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplier operand; captured on accept.
- b  input  WIDTH  multiplicand operand; captured on accept.
- n  input  WIDTH  modulus; captured on accept.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  (a*b) mod n; held until next accept.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, busy=0, done=0, result=0, internal P=0, counter=0. Reset mid-operation aborts the operation. No done is issued for the aborted operation.
- States:
  - IDLE: start=1 accepts the request. Capture a/b/n into a_r/b_r/n_r, set P=0, cnt=0, go to RUN. start=0 stays in IDLE.
  - RUN: each edge executes one step using bit i = a_r[WIDTH-1-cnt]:
    - T = 2*P + (i ? b_r : 0)
    - if T >= n_r then T = T - n_r
    - if T >= n_r then T = T - n_r
    - P <= T
  - RUN counting: if cnt != WIDTH-1, cnt <= cnt+1. If cnt == WIDTH-1, result <= T[WIDTH-1:0] and go to DONE.
  - DONE: done=1 for exactly this cycle; next edge goes to IDLE.
- Latency: accept edge k, WIDTH RUN edges k+1..k+WIDTH, done high in the cycle following edge k+WIDTH. Throughput is one op per WIDTH+2 cycles.
- busy = (state != IDLE), registered from state. done = (state == DONE).
- start while busy is ignored entirely and is not queued. Inputs a/b/n may change freely after accept.
- Arithmetic:
  - P is WIDTH bits; T and the compare/subtract path are WIDTH+2 bits, zero-extended.
  - Two conditional subtracts guarantee P < n_r each step, given the precondition.
- Precondition: n != 0, a < n, b < n. Violations give an unspecified result but the same timing.
- a = 0 or b = 0 gives result 0. n = 1 gives result 0.
- result is unchanged from one done until the DONE cycle of the next accepted op. It is not cleared on accept.

Optional Feature:
- MODMUL_RANGE_CHECK_EN
- Defined: adds output `err` (1 bit, reset 0).
  - On accept, err is registered as (n==0) || (a>=n) || (b>=n).
  - err is held until the next accept.
  - Operation timing is unchanged.
  - If err=1, result is forced to 0 at completion.
- Undefined: no err port, no comparators; precondition violations are unspecified.

Decomposition:
- Shared package rsa_pkg holds:
  - state enum mm_state_t {MM_IDLE, MM_RUN, MM_DONE}
  - default WIDTH constant RSA_WIDTH
  - CNTR_WIDTH constant
- One sub-module: modmul_step, purely combinational.
  - Inputs: P, b_r, n_r, bit.
  - Output: next P.
  - Reusable by a future radix-4 version.
- The FSM, counter and registers stay in mod_mult_interleaved.

Test Plan:
- WIDTH=8; a=7, b=9, n=13, start pulsed 1 cycle -> busy next cycle; done exactly 9 cycles after accept edge+1; result=11.
- WIDTH=8; a=254, b=254, n=255 -> result=1.
- WIDTH=8; a=12, b=12, n=13 -> result=1. Then a=0, b=5, n=13 -> result=0, with the previous result held until the new done.
- Start held high continuously with changing operands -> ops accepted only in IDLE, back-to-back spacing of 10 cycles (WIDTH+2). Each result matches the operands captured at its own accept.
- Assert rst low asynchronously (between edges) at RUN cycle 4 -> busy=0, done=0, result=0 immediately. No done pulse. A new start after release computes correctly.
- With MODMUL_RANGE_CHECK_EN: a=13, b=2, n=13 -> err=1, result=0 at done. A following a=3, b=4, n=13 -> err=0, result=12.
